// File: rtl/vga_arb_pkg.sv
// Shared types and constants for the VGA fetch arbiter.
package vga_arb_pkg;

   localparam int PIX_PER_WORD = 4;
   localparam int FRAME_WORDS  = 76800;
   localparam int WORD_W       = 16;

   // Owner of the memory slot in the current cycle.
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_DISP = 2'd1,
      GNT_CPU  = 2'd2
   } grant_e;

endpackage

// File: rtl/vga_word_fifo.sv
// Small prefetch FIFO for packed pixel words: push/pop/flush with an
// occupancy count. Pointers reset asynchronously; storage is not reset.
module vga_word_fifo #(
   parameter int W     = vga_arb_pkg::WORD_W,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [W-1:0]               head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   // A pop frees a slot, so a push into a full FIFO is allowed alongside it.
   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i && (do_pop || (cnt_q != (AW+1)'(DEPTH)));
   assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

   // Pointer and count bookkeeping; flush wins over push and pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

   // Word storage.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/vga_fetch_arbiter.sv
// Shares one single-port frame-buffer RAM between the display prefetch
// path and a CPU port. Display gets urgent priority below half-full,
// otherwise the CPU wins. Optional VGA_ARB_STATS_EN adds a saturating
// underflow_count output.
module vga_fetch_arbiter #(
   parameter int PIX_W        = 4,
   parameter int PIX_PER_WORD = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int ADDR_W       = 17,
   parameter int FRAME_WORDS  = 76800
) (
   input  logic                          clock,
   input  logic                          clear_n,
   input  logic                          vSync,
   input  logic                          bright,
   output logic [PIX_W-1:0]              pixel,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic                          mem_we,
   output logic [PIX_W*PIX_PER_WORD-1:0] mem_wdata,
   input  logic [PIX_W*PIX_PER_WORD-1:0] mem_rdata,
   input  logic                          cpu_req,
   input  logic                          cpu_we,
   input  logic [ADDR_W-1:0]             cpu_addr,
   input  logic [PIX_W*PIX_PER_WORD-1:0] cpu_wdata,
   output logic                          cpu_ack,
   output logic [PIX_W*PIX_PER_WORD-1:0] cpu_rdata,
   output logic                          cpu_rvalid,
   output logic                          underflow
`ifdef VGA_ARB_STATS_EN
   ,output logic [15:0]                  underflow_count
`endif
);

   import vga_arb_pkg::*;

   localparam int MW  = PIX_W * PIX_PER_WORD;
   localparam int PHW = $clog2(PIX_PER_WORD);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   logic              vs_q;
   logic              frame_start;
   logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
   logic [ADDR_W-1:0] addr_hold_q;
   logic              disp_inflight_q;
   logic              rd_pend_q;
   logic [PHW-1:0]    phase_q;
   logic [PIX_W-1:0]  pixel_q;
   logic              underflow_q;
   logic [CW-1:0]     fifo_count;
   logic [MW-1:0]     fifo_head;
   logic [CW-1:0]     occ;
   logic              fifo_empty;
   logic              disp_elig;
   logic              disp_urgent;
   logic              fifo_push;
   logic              fifo_pop;
   grant_e            gnt;

   // Frame start: vSync seen high last cycle and low now. No display fetch
   // is issued in that cycle so nothing from the old frame can slip through.
   assign frame_start = vs_q && !vSync;
   assign occ         = fifo_count + CW'(disp_inflight_q);
   assign fifo_empty  = (fifo_count == '0);
   assign disp_elig   = !frame_start && (occ < CW'(FIFO_DEPTH)) &&
                        (fetch_ptr_q < ADDR_W'(FRAME_WORDS));
   assign disp_urgent = disp_elig && (occ < CW'(FIFO_DEPTH / 2));

   // Slot arbitration: urgent display, then CPU, then opportunistic display.
   always_comb begin
      gnt = GNT_NONE;
      if (disp_urgent)    gnt = GNT_DISP;
      else if (cpu_req)   gnt = GNT_CPU;
      else if (disp_elig) gnt = GNT_DISP;
   end

   // Memory command and CPU ack are driven straight from the grant.
   always_comb begin
      mem_addr  = addr_hold_q;
      mem_we    = 1'b0;
      mem_wdata = '0;
      cpu_ack   = 1'b0;
      case (gnt)
         GNT_DISP: mem_addr = fetch_ptr_q;
         GNT_CPU: begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
            cpu_ack   = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      fetch_ptr_d = fetch_ptr_q;
      if (frame_start)          fetch_ptr_d = '0;
      else if (gnt == GNT_DISP) fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
   end

   // Fetch pointer, in-flight tracking and the CPU read-return flag.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         vs_q            <= 1'b0;
         fetch_ptr_q     <= '0;
         addr_hold_q     <= '0;
         disp_inflight_q <= 1'b0;
         rd_pend_q       <= 1'b0;
      end else begin
         vs_q            <= vSync;
         fetch_ptr_q     <= fetch_ptr_d;
         addr_hold_q     <= mem_addr;
         disp_inflight_q <= (gnt == GNT_DISP);
         rd_pend_q       <= (gnt == GNT_CPU) && !cpu_we;
      end
   end

   assign cpu_rvalid = rd_pend_q;
   assign cpu_rdata  = rd_pend_q ? mem_rdata : '0;

   // A read landing in the frame-start cycle belongs to the old frame.
   assign fifo_push = disp_inflight_q && !frame_start;
   assign fifo_pop  = bright && !fifo_empty && (phase_q == PHW'(PIX_PER_WORD - 1));

   vga_word_fifo #(
      .W     (MW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (clear_n),
      .push_i  (fifo_push),
      .data_i  (mem_rdata),
      .pop_i   (fifo_pop),
      .flush_i (frame_start),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   // Pixel unpack, LSB pixel first; an empty FIFO yields black and flags underflow.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         phase_q     <= '0;
         pixel_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         if (bright) begin
            pixel_q <= fifo_empty ? '0 : fifo_head[phase_q*PIX_W +: PIX_W];
            phase_q <= phase_q + PHW'(1);
         end
         if (frame_start) begin
            phase_q     <= '0;
            underflow_q <= 1'b0;
         end else if (bright && fifo_empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign pixel     = pixel_q;
   assign underflow = underflow_q;

`ifdef VGA_ARB_STATS_EN
   logic [15:0] uf_cnt_q;

   // Saturating count of underflow pixel cycles; survives frame starts.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         uf_cnt_q <= '0;
      end else if (bright && fifo_empty && (uf_cnt_q != 16'hFFFF)) begin
         uf_cnt_q <= uf_cnt_q + 16'd1;
      end
   end

   assign underflow_count = uf_cnt_q;
`endif

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed bench for vga_fetch_arbiter with a behavioural frame-buffer RAM.
// RAM word a holds pixels (4a..4a+3) mod 16, so pixel n of a frame is n mod 16.
module tb_vga_fetch_arbiter;

   logic        clock = 1'b0;
   logic        clear_n;
   logic        vSync;
   logic        bright;
   logic [3:0]  pixel;
   logic [16:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0;
   logic        cpu_req;
   logic        cpu_we;
   logic [16:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        cpu_rvalid;
   logic        underflow;
`ifdef VGA_ARB_STATS_EN
   logic [15:0] underflow_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] ovl [logic [16:0]];

   vga_fetch_arbiter dut (
      .clock      (clock),
      .clear_n    (clear_n),
      .vSync      (vSync),
      .bright     (bright),
      .pixel      (pixel),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .cpu_rvalid (cpu_rvalid),
      .underflow  (underflow)
`ifdef VGA_ARB_STATS_EN
      ,.underflow_count (underflow_count)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] pat(input logic [16:0] a);
      logic [3:0] b;
      b = {a[1:0], 2'b00};
      return {b + 4'd3, b + 4'd2, b + 4'd1, b};
   endfunction

   // Synchronous single-port RAM: read data valid the cycle after the command.
   always @(posedge clock) begin
      logic [15:0] rd;
      rd = ovl.exists(mem_addr) ? ovl[mem_addr] : pat(mem_addr);
      if (mem_we) ovl[mem_addr] = mem_wdata;
      mem_rdata <= rd;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic exp_ack(input int t);
      return !(t >= 12 && (t % 4) == 0);
   endfunction

   initial begin
      clear_n   = 1'b0;
      vSync     = 1'b1;
      bright    = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;

      // Reset state
      repeat (3) tick();
      @(negedge clock);
      check("rst_pixel", pixel, 0);
      check("rst_underflow", underflow, 0);
      check("rst_ack", cpu_ack, 0);
      check("rst_rvalid", cpu_rvalid, 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_we", mem_we, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_addr", mem_addr, 0);
      tick();
      clear_n = 1'b1;

      // Initial prefetch: four consecutive display reads, then idle
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("prefetch_addr", mem_addr, i);
         check("prefetch_we", mem_we, 0);
         check("prefetch_ack", cpu_ack, 0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("idle_addr_hold", mem_addr, 3);
         check("idle_ack", cpu_ack, 0);
         tick();
      end

      // One active line of 640 pixels
      for (int k = 0; k < 640; k++) begin
         bright = 1'b1;
         tick();
         check("line_pixel", pixel, k & 15);
      end
      bright = 1'b0;
      check("line_underflow", underflow, 0);
      repeat (8) tick();

      // CPU holding reads during active video
      for (int t = 0; t < 32; t++) begin
         bright   = 1'b1;
         cpu_req  = 1'b1;
         cpu_we   = 1'b0;
         cpu_addr = 17'h00010;
         @(negedge clock);
         check("busy_ack", cpu_ack, exp_ack(t));
         check("busy_rvalid", cpu_rvalid, (t == 0) ? 1'b0 : exp_ack(t - 1));
         if (t > 0 && exp_ack(t - 1)) check("busy_rdata", cpu_rdata, pat(17'h00010));
         tick();
         check("busy_pixel", pixel, t & 15);
      end
      bright  = 1'b0;
      cpu_req = 1'b0;
      @(negedge clock);
      check("busy_last_rvalid", cpu_rvalid, 1);
      check("busy_last_rdata", cpu_rdata, pat(17'h00010));
      check("busy_underflow", underflow, 0);
      repeat (8) tick();

      // CPU write then read back
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 17'h12345;
      cpu_wdata = 16'hBEEF;
      @(negedge clock);
      check("wr_ack", cpu_ack, 1);
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, 17'h12345);
      check("wr_wdata", mem_wdata, 16'hBEEF);
      tick();
      cpu_we = 1'b0;
      @(negedge clock);
      check("rd_ack", cpu_ack, 1);
      check("rd_we", mem_we, 0);
      check("rd_addr", mem_addr, 17'h12345);
      check("wr_no_rvalid", cpu_rvalid, 0);
      tick();
      cpu_req = 1'b0;
      @(negedge clock);
      check("rd_rvalid", cpu_rvalid, 1);
      check("rd_rdata", cpu_rdata, 16'hBEEF);
      tick();
      repeat (4) tick();

      // Frame start, then bright from the next cycle: underflow until first push
      vSync = 1'b0;
      tick();
      for (int j = 0; j < 12; j++) begin
         bright = 1'b1;
         tick();
         check("uf_pixel", pixel, (j < 2) ? 0 : (j & 15));
         if (j < 2) check("uf_flag_early", underflow, 1);
      end
      bright = 1'b0;
      check("uf_sticky", underflow, 1);
      vSync = 1'b1;
      repeat (2) tick();
      vSync = 1'b0;
      tick();
      check("uf_cleared", underflow, 0);

      // vSync falls while a display read is in flight
      vSync = 1'b1;
      @(negedge clock);
      check("disc_first_addr", mem_addr, 0);
      check("disc_first_ack", cpu_ack, 0);
      tick();
      vSync = 1'b0;
      tick();
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 17'h00020;
      @(negedge clock);
      check("disc_restart_addr", mem_addr, 0);
      check("disc_restart_ack", cpu_ack, 0);
      tick();
      @(negedge clock);
      check("disc_next_addr", mem_addr, 1);
      check("disc_next_ack", cpu_ack, 0);
      tick();
      @(negedge clock);
      check("disc_cpu_ack", cpu_ack, 1);
      check("disc_cpu_addr", mem_addr, 17'h00020);
      tick();
      cpu_req = 1'b0;
      repeat (6) tick();

      // Reset right after a read ack suppresses its return
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 17'h00005;
      @(negedge clock);
      check("abort_ack", cpu_ack, 1);
      #1;
      clear_n = 1'b0;
      cpu_req = 1'b0;
      tick();
      check("abort_rvalid", cpu_rvalid, 0);
      check("abort_rdata", cpu_rdata, 0);
      clear_n = 1'b1;
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_fetch_arbiter.md
# vga_fetch_arbiter

Shares one single-port pixel memory between the VGA display path and a CPU port. The display path prefetches packed pixel words into a small FIFO and emits one pixel per clock while `bright` is high. The CPU port gets every memory slot the display does not need. It sits between the VGA timing generator (`hCount`/`vCount`/`bright`/`vSync`) and the frame-buffer RAM.

## Interface
- `PIX_W`, 4: bits per pixel.
- `PIX_PER_WORD`, 4: pixels packed per memory word. Memory word width is `PIX_W*PIX_PER_WORD` (16).
- `FIFO_DEPTH`, 4: prefetch words; power of two.
- `ADDR_W`, 17: memory word address width.
- `FRAME_WORDS`, 76800: words per frame (640*480/4).
- `clock` in 1: system/pixel clock.
- `clear_n` in 1: asynchronous, active-low reset.
- `vSync` in 1: from timing generator, active low.
- `bright` in 1: from timing generator; consume one pixel this cycle.
- `pixel` out PIX_W: pixel for the previous `bright` cycle.
- `mem_addr` out ADDR_W, `mem_we` out 1, `mem_wdata` out 16: RAM command, issued every cycle.
- `mem_rdata` in 16: valid the cycle after a read command.
- `cpu_req` in 1, `cpu_we` in 1, `cpu_addr` in ADDR_W, `cpu_wdata` in 16: CPU request, held until ack.
- `cpu_ack` out 1: one-cycle grant pulse.
- `cpu_rdata` out 16, `cpu_rvalid` out 1: read return, the cycle after `cpu_ack`.
- `underflow` out 1: sticky. Set when `bright` pops an empty FIFO. Cleared at frame start.

## Operation
- Occupancy: `occ = fifo_count + disp_inflight` (0..FIFO_DEPTH).
- Display fetch is eligible when `occ < FIFO_DEPTH` and `fetch_ptr < FRAME_WORDS`.
- Arbitration, one grant per cycle, evaluated combinationally and issued that cycle:
  - If display is eligible and `occ < FIFO_DEPTH/2`, grant DISP (urgent).
  - Otherwise, if `cpu_req` is high, grant CPU.
  - Otherwise, if display is eligible, grant DISP.
  - Otherwise, grant NONE (`mem_we`=0, address held).
- DISP grant:
  - `mem_addr=fetch_ptr`, `mem_we=0`.
  - `fetch_ptr++`.
  - Set `disp_inflight`.
  - Next cycle, push `mem_rdata` into the FIFO.
- CPU grant:
  - `mem_addr=cpu_addr`, `mem_we=cpu_we`, `mem_wdata=cpu_wdata`, `cpu_ack=1`.
  - For a read, the next cycle drives `cpu_rdata=mem_rdata` and `cpu_rvalid=1`.
  - A write completes at ack.
  - The CPU must hold its request until ack. It may issue the next request in the cycle after ack.
- Pixel unpack:
  - A 2-bit `phase` increments on each `bright` cycle.
  - The selected pixel is `head[phase*PIX_W +: PIX_W]`, LSB pixel first.
  - On `phase==PIX_PER_WORD-1` with `bright`, pop the head.
  - If the FIFO is empty on a `bright` cycle: `pixel` is 0, `underflow` is set, and `phase` still advances.
- Frame start is the registered falling edge of `vSync`. On that edge:
  - Flush the FIFO.
  - `fetch_ptr=0`, `phase=0`, clear `underflow`.
  - Mark any display read in flight as discarded; its data is not pushed.
  - CPU transactions are unaffected.
- Push and pop in the same cycle is legal and leaves `fifo_count` unchanged.

## Timing
- Reset values: `pixel`, `mem_addr`, `mem_we`, `mem_wdata`, `cpu_ack`, `cpu_rdata`, `cpu_rvalid`, `underflow` = 0. Internal pointers, phase and counts = 0.
- Memory outputs are combinational from the grant.
- `pixel` is registered: 1-cycle latency from `bright`.
- Display bandwidth is 1 slot in `PIX_PER_WORD` during active video. The CPU is guaranteed at least 3 of 4 slots in active video and all slots once the FIFO is full.
- FIFO refills from empty to full in `FIFO_DEPTH` cycles. The horizontal blanking interval of 160 cycles guarantees a full FIFO at every line start.
- Reset asserted mid-transaction aborts it. No `cpu_rvalid` is produced for a read acked before reset.

## Configuration
- `VGA_ARB_STATS_EN`: adds output `underflow_count` [15:0].
  - Saturating count of underflow pixel cycles since reset.
  - Not cleared at frame start.
- Without the macro, the port and counter are absent; `underflow` is unchanged.

## Structure
- Package `vga_arb_pkg` holds:
  - grant enum `GNT_NONE/GNT_DISP/GNT_CPU`.
  - constants `PIX_PER_WORD`, `FRAME_WORDS`, `WORD_W`.
- Sub-module `vga_word_fifo`: synchronous FIFO with `FIFO_DEPTH` entries, push/pop/flush, `count` output, async active-low reset.

## Test plan
- Reset then idle with `vSync` toggled and `bright`=0: 4 DISP reads at addresses 0..3 in consecutive cycles, then NONE. `cpu_ack` stays 0.
- Active line with `bright`=1 for 640 cycles and words 0x3210, 0x7654 preloaded: `pixel` sequence is 0,1,2,3,4,5,6,7… one cycle after `bright`. `underflow` stays 0.
- `cpu_req` held continuously during active video: `cpu_ack` pulses in 3 of every 4 cycles. No display underflow. Read of 0x00010 returns the RAM value with `cpu_rvalid` one cycle after ack.
- CPU write of 0xBEEF at 0x12345 then a read of the same address: `mem_we`=1 at ack, and the read returns 0xBEEF.
- `bright` forced high from the cycle after frame start: `pixel`=0 and `underflow`=1 until the first push. `underflow` is cleared by the next `vSync` falling edge.
- `vSync` falls while a display read is in flight: the discarded data is not pushed, and the next fetch address is 0.
